audio_dac_tx: RTL and testbench
===============================

Name: audio_dac_tx

Overview:
Parametrised serial audio transmitter driving an external I2S-family DAC (TDA1543-class or later parts) from the console audio path. It generalises the current fixed stereo 16-bit DAC feed with configurable sample width, slot width, channel count (2..8, TDM beyond stereo) and frame format. It also adds a valid/ready sample handshake with a one-frame holding buffer and underrun accounting. It sits between the APU audio mixer and the DAC pins, all in the system clock domain.

Parameters:
DATA_W, 16, sample bits per channel (1..24)
SLOT_W, 16, BCK periods per channel slot; must be >= DATA_W
CHANNELS, 2, channels per frame; even, 2..8
BCK_DIV, 2, clk_in cycles per BCK half-period (>=1)
FORMAT, 0, 0 = I2S (one-bit WS lead), 1 = left-justified, 2 = right-justified

Ports:
clk_in  input  1  system clock, single clock domain
rst_in  input  1  asynchronous, active-high reset
sample_in  input  CHANNELS*DATA_W  channel 0 in LSBs; each channel two's complement
sample_valid_in  input  1  sample_in valid
sample_ready_out  output  1  holding buffer empty; transfer when valid && ready
bck_out  output  1  DAC bit clock
ws_out  output  1  word select; low = first half of channels (left)
data_out  output  1  serial data, MSB first
frame_start_out  output  1  one-clk pulse when a new frame begins
underrun_cnt_out  output  8  saturating count of frames started without new data

Behaviour:
- Reset: bck_out=0; ws_out, data_out, frame_start_out and underrun_cnt_out = 0; sample_ready_out=1; active and holding registers=0; bit index=0; armed=0.
- BCK generation: divider counts 0..BCK_DIV-1 and toggles bck_out at the terminal count. Frame = CHANNELS*SLOT_W BCK periods = 2*BCK_DIV*CHANNELS*SLOT_W clocks.
- Falling-edge update: ws_out and data_out change only in the clock where bck_out goes 1->0, and are stable across each rising edge. The bit index b (0..CHANNELS*SLOT_W-1) advances on each falling edge and wraps to 0.
- Slot decoding: slot s = b / SLOT_W, position p = b % SLOT_W.
- Left-justified: ws = (s >= CHANNELS/2). data = channel s bit DATA_W-1-p for p < DATA_W, else 0.
- Right-justified: ws as left-justified. data = bit SLOT_W-1-p for p >= SLOT_W-DATA_W, else the sign bit (sign extension).
- I2S: ws and data equal the left-justified values for index b+1 and b-1 respectively, mod frame length. Data at b=0 is the last bit of the previous frame's final slot.
- Frame start: on the falling edge where b wraps to 0:
  - The holding register, if full, is copied to the active register and the holding register becomes empty.
  - If holding is empty and sample_valid_in=1 in that same clock, sample_in loads the active register directly (bypass); no underrun is counted and holding stays empty.
  - Otherwise, if holding is empty, the active register is retained and, when armed, underrun_cnt_out increments, saturating at 255.
  - frame_start_out pulses for this clock.
- Handshake: sample_ready_out = ~hold_full, registered. A transfer sets hold_full on the next clock and sets armed. Valid while not ready is ignored, with no error. The input need not be held after the transfer.
- Latency: a sample accepted during frame N is output in frame N+1. Its first MSB appears on the falling edge at b=0 (LJ/RJ) or b=1 (I2S).
- Reset mid-frame: all outputs return to reset values immediately (asynchronous) and the current frame is abandoned.
- Parameter check: SLOT_W < DATA_W or odd CHANNELS fails elaboration.

Optional Feature:
AUDIO_DAC_UNSIGNED_IN_EN: when defined, each channel of sample_in is treated as unsigned (offset binary, as the APU produces). Its MSB is inverted on entry to the holding/bypass path, converting it to two's complement. When undefined, sample_in passes unmodified as two's complement. All serialisation timing is identical in both builds.

Test Plan:
- Defaults, reset then accept sample_in=32'h8001_1234 before the first frame start -> ws_out falls at b=31; bits 1..16 carry 0x1234 MSB-first with ws low; bits 17..31 and 0 of the next frame carry 0x8001; frame length 128 clocks.
- FORMAT=1, same data -> 0x1234 on bits 0..15 with ws=0, 0x8001 on bits 16..31 with ws=1; no one-bit delay.
- FORMAT=2, DATA_W=12, SLOT_W=16, channel 0 = 12'h800 -> slot bits 0..4 =1 (sign extension plus MSB), bits 5..15 =0.
- Accept one sample, then hold valid low for 3 frames -> same sample repeated, underrun_cnt_out = 3. Before the first accepted sample, frames output zeros and the count stays 0.
- Assert sample_valid_in with the holding register empty exactly on the frame-start clock -> bypass load, no underrun, sample_ready_out stays 1.
- Assert rst_in mid-frame at b=10 -> bck_out, ws_out and data_out go 0 asynchronously; after release the frame restarts at b=0 and the counter reads 0; with AUDIO_DAC_UNSIGNED_IN_EN, input 16'h8000 serialises as 0x0000.

Source files
------------

// File: rtl/audio_dac_tx.sv
// audio_dac_tx: parametrised I2S / left-justified / right-justified / TDM
// serial transmitter for an external audio DAC. A one-frame holding buffer
// with a valid/ready handshake sits in front of the active (serialising)
// register, and frames started without fresh data are counted as underruns.
// Optional build macro: AUDIO_DAC_UNSIGNED_IN_EN (offset-binary input,
// converted to two's complement by inverting each channel MSB on entry).
module audio_dac_tx #(
   parameter int DATA_W   = 16,
   parameter int SLOT_W   = 16,
   parameter int CHANNELS = 2,
   parameter int BCK_DIV  = 2,
   parameter int FORMAT   = 0
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [CHANNELS*DATA_W-1:0]   sample_in,
   input  logic                         sample_valid_in,
   output logic                         sample_ready_out,
   output logic                         bck_out,
   output logic                         ws_out,
   output logic                         data_out,
   output logic                         frame_start_out,
   output logic [7:0]                   underrun_cnt_out
);

   localparam int W  = CHANNELS * DATA_W;
   localparam int SW = $clog2(CHANNELS + 1);
   localparam int PW = $clog2(SLOT_W + 1);
   localparam int DW = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;

   localparam logic [DW-1:0] DIV_LAST  = DW'(BCK_DIV - 1);
   localparam logic [PW-1:0] POS_LAST  = PW'(SLOT_W - 1);
   localparam logic [SW-1:0] SLOT_LAST = SW'(CHANNELS - 1);
   localparam logic [SW-1:0] SLOT_HALF = SW'(CHANNELS / 2);

   // Reject parameter sets the slot/channel arithmetic cannot represent.
   generate
      if ((SLOT_W < DATA_W) || ((CHANNELS % 2) != 0) || (CHANNELS < 2) || (CHANNELS > 8) ||
          (DATA_W < 1) || (DATA_W > 24) || (BCK_DIV < 1) || (FORMAT < 0) || (FORMAT > 2)) begin : g_bad_params
         $error("audio_dac_tx: illegal parameter combination");
      end
   endgenerate

   // Input conversion: offset binary to two's complement when the unsigned build is selected.
   function automatic logic [W-1:0] to_twos(input logic [W-1:0] raw);
      logic [W-1:0] conv;
      conv = raw;
`ifdef AUDIO_DAC_UNSIGNED_IN_EN
      for (int c = 0; c < CHANNELS; c++) begin
         conv[c*DATA_W + DATA_W - 1] = ~raw[c*DATA_W + DATA_W - 1];
      end
`else
      conv = raw;
`endif
      return conv;
   endfunction

   // Word select for a slot: low for the first half of the channels.
   function automatic logic ws_at(input logic [SW-1:0] s);
      return (s >= SLOT_HALF);
   endfunction

   // Serial bit for slot s / position p of word w, in left- or right-justified layout.
   function automatic logic bit_at(input logic [W-1:0] w, input logic [SW-1:0] s,
                                   input logic [PW-1:0] p);
      logic [DATA_W-1:0] ch;
      logic              b;
      ch = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         ch = (s == SW'(c)) ? w[c*DATA_W +: DATA_W] : ch;
      end
      // Right-justified pads the leading positions with the sign bit; the others pad trailing zeros.
      b = (FORMAT == 2) ? ch[DATA_W-1] : 1'b0;
      for (int k = 0; k < DATA_W; k++) begin
         if (FORMAT == 2) begin
            b = (p == PW'(SLOT_W - 1 - k)) ? ch[k] : b;
         end else begin
            b = (p == PW'(DATA_W - 1 - k)) ? ch[k] : b;
         end
      end
      return b;
   endfunction

   logic [DW-1:0] div_q, div_d;
   logic          bck_q, bck_d;
   logic [SW-1:0] slot_q, slot_d;
   logic [PW-1:0] pos_q, pos_d;
   logic          ws_q, ws_d;
   logic          data_q, data_d;
   logic          frame_start_q, frame_start_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          ready_q, ready_d;
   logic          hold_full_q, hold_full_d;
   logic [W-1:0]  hold_q, hold_d;
   logic [W-1:0]  active_q, active_d;
   logic          armed_q, armed_d;

   logic          fall_s;
   logic          frame_end_s;
   logic [W-1:0]  in_s;
   logic [SW-1:0] slot_nx_s, slot_nx2_s;
   logic [PW-1:0] pos_nx_s;

   // Bit-clock divider: toggle BCK at the terminal count; a falling edge marks a bit update.
   always_comb begin
      div_d  = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
      bck_d  = (div_q == DIV_LAST) ? ~bck_q : bck_q;
      fall_s = (div_q == DIV_LAST) && bck_q;
   end

   // Slot/position counters for the next bit index and the one after it (I2S WS lead).
   always_comb begin
      frame_end_s = (slot_q == SLOT_LAST) && (pos_q == POS_LAST);
      pos_nx_s    = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      if (pos_q == POS_LAST) begin
         slot_nx_s = (slot_q == SLOT_LAST) ? '0 : slot_q + SW'(1);
      end else begin
         slot_nx_s = slot_q;
      end
      if (pos_nx_s == POS_LAST) begin
         slot_nx2_s = (slot_nx_s == SLOT_LAST) ? '0 : slot_nx_s + SW'(1);
      end else begin
         slot_nx2_s = slot_nx_s;
      end
   end

   // Sample path: handshake into the holding register, frame-start reload/bypass, underrun count.
   always_comb begin
      in_s          = to_twos(sample_in);
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      active_d      = active_q;
      armed_d       = armed_q;
      cnt_d         = cnt_q;
      frame_start_d = fall_s && frame_end_s;
      if (fall_s && frame_end_s) begin
         if (hold_full_q) begin
            active_d    = hold_q;
            hold_full_d = 1'b0;
         end else if (sample_valid_in) begin
            // Holding is empty, so ready is high: this clock is a transfer straight to active.
            active_d = in_s;
            armed_d  = 1'b1;
         end else if (armed_q && (cnt_q != 8'hFF)) begin
            cnt_d = cnt_q + 8'd1;
         end else begin
            cnt_d = cnt_q;
         end
      end else if (sample_valid_in && ready_q) begin
         hold_d      = in_s;
         hold_full_d = 1'b1;
         armed_d     = 1'b1;
      end else begin
         hold_d = hold_q;
      end
      ready_d = ~hold_full_d;
   end

   // Serialiser: advance the bit index and update WS/data only on BCK falling edges.
   always_comb begin
      slot_d = slot_q;
      pos_d  = pos_q;
      ws_d   = ws_q;
      data_d = data_q;
      if (fall_s) begin
         slot_d = slot_nx_s;
         pos_d  = pos_nx_s;
         if (FORMAT == 0) begin
            // I2S: WS leads by one bit, data lags by one bit (index b-1 is the current b).
            ws_d   = ws_at(slot_nx2_s);
            data_d = bit_at(active_q, slot_q, pos_q);
         end else begin
            ws_d   = ws_at(slot_nx_s);
            data_d = bit_at(active_d, slot_nx_s, pos_nx_s);
         end
      end else begin
         ws_d = ws_q;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         div_q         <= '0;
         bck_q         <= 1'b0;
         slot_q        <= '0;
         pos_q         <= '0;
         ws_q          <= 1'b0;
         data_q        <= 1'b0;
         frame_start_q <= 1'b0;
         cnt_q         <= 8'd0;
         ready_q       <= 1'b1;
         hold_full_q   <= 1'b0;
         hold_q        <= '0;
         active_q      <= '0;
         armed_q       <= 1'b0;
      end else begin
         div_q         <= div_d;
         bck_q         <= bck_d;
         slot_q        <= slot_d;
         pos_q         <= pos_d;
         ws_q          <= ws_d;
         data_q        <= data_d;
         frame_start_q <= frame_start_d;
         cnt_q         <= cnt_d;
         ready_q       <= ready_d;
         hold_full_q   <= hold_full_d;
         hold_q        <= hold_d;
         active_q      <= active_d;
         armed_q       <= armed_d;
      end
   end

   assign sample_ready_out = ready_q;
   assign bck_out          = bck_q;
   assign ws_out           = ws_q;
   assign data_out         = data_q;
   assign frame_start_out  = frame_start_q;
   assign underrun_cnt_out = cnt_q;

endmodule

// File: tb/tb_audio_dac_tx.sv
// Directed bench for audio_dac_tx: three instances (I2S 16/16, left-justified
// 16/16, right-justified 12/16) share clock, reset and valid and run in
// lockstep with 128-clock frames. Serial streams are captured MSB-first
// (first transmitted bit ends up in bit 31) and compared to hand-computed words.
module tb_audio_dac_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        valid = 1'b0;
   logic [31:0] smp32 = 32'h0;
   logic [23:0] smp24 = 24'h0;

   logic rdy_i, bck_i, ws_i, dat_i, fs_i;
   logic rdy_l, bck_l, ws_l, dat_l, fs_l;
   logic rdy_r, bck_r, ws_r, dat_r, fs_r;
   logic [7:0] cnt_i, cnt_l, cnt_r;

   int checks = 0;
   int failures = 0;

`ifdef AUDIO_DAC_UNSIGNED_IN_EN
   localparam logic [31:0] LJ_A   = 32'h9234_0001;
   localparam logic [31:0] I2S_A0 = 32'h491A_0000;
   localparam logic [31:0] I2S_A1 = 32'hC91A_0000;
   localparam logic [31:0] RJ_A   = 32'h0000_FBA5;
   localparam logic [31:0] LJ_B   = 32'h80FF_DA5A;
   localparam logic [31:0] I2S_B  = 32'hC07F_ED2D;
   localparam logic [31:0] RJ_B   = 32'h07FF_F801;
   localparam logic [31:0] LJ_C   = 32'h0000_0000;
   localparam logic [31:0] I2S_C  = 32'h0000_0000;
`else
   localparam logic [31:0] LJ_A   = 32'h1234_8001;
   localparam logic [31:0] I2S_A0 = 32'h091A_4000;
   localparam logic [31:0] I2S_A1 = 32'h891A_4000;
   localparam logic [31:0] RJ_A   = 32'hF800_03A5;
   localparam logic [31:0] LJ_B   = 32'h00FF_5A5A;
   localparam logic [31:0] I2S_B  = 32'h807F_AD2D;
   localparam logic [31:0] RJ_B   = 32'hFFFF_0001;
   localparam logic [31:0] LJ_C   = 32'h8000_8000;
   localparam logic [31:0] I2S_C  = 32'h4000_4000;
`endif
   localparam logic [31:0] WS_I2S = 32'h0001_FFFE;
   localparam logic [31:0] WS_LJ  = 32'h0000_FFFF;

   audio_dac_tx #(.DATA_W(16), .SLOT_W(16), .CHANNELS(2), .BCK_DIV(2), .FORMAT(0)) dut_i2s (
      .clk_in(clk), .rst_in(rst), .sample_in(smp32), .sample_valid_in(valid),
      .sample_ready_out(rdy_i), .bck_out(bck_i), .ws_out(ws_i), .data_out(dat_i),
      .frame_start_out(fs_i), .underrun_cnt_out(cnt_i));

   audio_dac_tx #(.DATA_W(16), .SLOT_W(16), .CHANNELS(2), .BCK_DIV(2), .FORMAT(1)) dut_lj (
      .clk_in(clk), .rst_in(rst), .sample_in(smp32), .sample_valid_in(valid),
      .sample_ready_out(rdy_l), .bck_out(bck_l), .ws_out(ws_l), .data_out(dat_l),
      .frame_start_out(fs_l), .underrun_cnt_out(cnt_l));

   audio_dac_tx #(.DATA_W(12), .SLOT_W(16), .CHANNELS(2), .BCK_DIV(2), .FORMAT(2)) dut_rj (
      .clk_in(clk), .rst_in(rst), .sample_in(smp24), .sample_valid_in(valid),
      .sample_ready_out(rdy_r), .bck_out(bck_r), .ws_out(ws_r), .data_out(dat_r),
      .frame_start_out(fs_r), .underrun_cnt_out(cnt_r));

   always #5 clk = ~clk;

   // Capture one full frame from all three instances, starting at the next frame-start pulse.
   task automatic capture(output logic [31:0] ci, output logic [31:0] wi,
                          output logic [31:0] cl, output logic [31:0] wl,
                          output logic [31:0] cr, output logic [31:0] wr,
                          output logic n0, output int bad);
      int n;
      n = 0;
      ci = 32'h0; wi = 32'h0; cl = 32'h0; wl = 32'h0; cr = 32'h0; wr = 32'h0;
      while (fs_i !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 400) begin
         failures++;
         $display("FAIL frame_start_timeout: waited %0d cycles, limit 400", n);
      end
      bad = 0;
      for (int b = 0; b < 32; b++) begin
         ci = {ci[30:0], dat_i}; wi = {wi[30:0], ws_i};
         cl = {cl[30:0], dat_l}; wl = {wl[30:0], ws_l};
         cr = {cr[30:0], dat_r}; wr = {wr[30:0], ws_r};
         for (int k = 0; k < 4; k++) begin
            if (bck_i !== ((k < 2) ? 1'b0 : 1'b1)) bad++;
            if ((b != 0 || k != 0) && (fs_i !== 1'b0 || fs_l !== 1'b0 || fs_r !== 1'b0)) bad++;
            @(negedge clk);
         end
      end
      n0 = dat_i;
      if (fs_i !== 1'b1 || fs_l !== 1'b1 || fs_r !== 1'b1) bad++;
   endtask

   // Offer one sample and wait (bounded) for the transfer into the holding register.
   task automatic send(input logic [31:0] s32, input logic [23:0] s24);
      int n;
      smp32 = s32; smp24 = s24; valid = 1'b1; n = 0;
      while (rdy_i !== 1'b1 && n < 300) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n >= 300) begin failures++; $display("FAIL send_timeout: waited %0d cycles, limit 300", n); end
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      checks++;
      if (rdy_i !== 1'b0) begin failures++; $display("FAIL ready_after_send: got %b expected 0", rdy_i); end
   endtask

   task automatic test_reset();
      #2 rst = 1'b1;
      @(negedge clk);
      checks++; if (bck_i !== 1'b0) begin failures++; $display("FAIL reset_bck: got %b expected 0", bck_i); end
      checks++; if (ws_i !== 1'b0) begin failures++; $display("FAIL reset_ws: got %b expected 0", ws_i); end
      checks++; if (dat_i !== 1'b0) begin failures++; $display("FAIL reset_data: got %b expected 0", dat_i); end
      checks++; if (fs_i !== 1'b0) begin failures++; $display("FAIL reset_frame_start: got %b expected 0", fs_i); end
      checks++; if (cnt_i !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", cnt_i); end
      checks++; if (rdy_i !== 1'b1) begin failures++; $display("FAIL reset_ready: got %b expected 1", rdy_i); end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_idle();
      logic [31:0] ci, wi, cl, wl, cr, wr;
      logic n0;
      int bad;
      capture(ci, wi, cl, wl, cr, wr, n0, bad);
      checks++; if (ci !== 32'h0) begin failures++; $display("FAIL idle_i2s_data: got %h expected 00000000", ci); end
      checks++; if (cl !== 32'h0) begin failures++; $display("FAIL idle_lj_data: got %h expected 00000000", cl); end
      checks++; if (cr !== 32'h0) begin failures++; $display("FAIL idle_rj_data: got %h expected 00000000", cr); end
      checks++; if (wi !== WS_I2S) begin failures++; $display("FAIL idle_i2s_ws: got %h expected %h", wi, WS_I2S); end
      checks++; if (cnt_i !== 8'd0) begin failures++; $display("FAIL idle_cnt: got %0d expected 0", cnt_i); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL idle_timing: got %0d errors expected 0", bad); end
   endtask

   task automatic test_formats();
      logic [31:0] ci, wi, cl, wl, cr, wr;
      logic n0;
      int bad;
      send(32'h8001_1234, {12'h3A5, 12'h800});
      capture(ci, wi, cl, wl, cr, wr, n0, bad);
      checks++; if (ci !== I2S_A0) begin failures++; $display("FAIL i2s_data: got %h expected %h", ci, I2S_A0); end
      checks++; if (n0 !== 1'b1) begin failures++; $display("FAIL i2s_next_b0: got %b expected 1", n0); end
      checks++; if (wi !== WS_I2S) begin failures++; $display("FAIL i2s_ws: got %h expected %h", wi, WS_I2S); end
      checks++; if (cl !== LJ_A) begin failures++; $display("FAIL lj_data: got %h expected %h", cl, LJ_A); end
      checks++; if (wl !== WS_LJ) begin failures++; $display("FAIL lj_ws: got %h expected %h", wl, WS_LJ); end
      checks++; if (cr !== RJ_A) begin failures++; $display("FAIL rj_data: got %h expected %h", cr, RJ_A); end
      checks++; if (wr !== WS_LJ) begin failures++; $display("FAIL rj_ws: got %h expected %h", wr, WS_LJ); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL format_timing: got %0d errors expected 0", bad); end
      checks++; if (rdy_i !== 1'b1) begin failures++; $display("FAIL ready_after_reload: got %b expected 1", rdy_i); end
      checks++; if (cnt_i !== 8'd1) begin failures++; $display("FAIL cnt_after_first_repeat: got %0d expected 1", cnt_i); end
   endtask

   task automatic test_underrun();
      logic [31:0] ci, wi, cl, wl, cr, wr;
      logic n0;
      int bad;
      for (int f = 0; f < 2; f++) begin
         capture(ci, wi, cl, wl, cr, wr, n0, bad);
         checks++; if (ci !== I2S_A1) begin failures++; $display("FAIL repeat_i2s_data: got %h expected %h", ci, I2S_A1); end
         checks++; if (cl !== LJ_A) begin failures++; $display("FAIL repeat_lj_data: got %h expected %h", cl, LJ_A); end
         checks++; if (cr !== RJ_A) begin failures++; $display("FAIL repeat_rj_data: got %h expected %h", cr, RJ_A); end
         checks++; if (cnt_i !== 8'(f + 2)) begin failures++; $display("FAIL underrun_cnt: got %0d expected %0d", cnt_i, f + 2); end
      end
      checks++; if (cnt_r !== 8'd3) begin failures++; $display("FAIL underrun_cnt_rj: got %0d expected 3", cnt_r); end
   endtask

   task automatic test_bypass();
      logic [31:0] ci, wi, cl, wl, cr, wr;
      logic n0;
      int bad;
      // Now at a frame start; the next frame-start edge is 128 clocks away.
      for (int k = 0; k < 127; k++) @(negedge clk);
      smp32 = 32'h5A5A_00FF; smp24 = {12'h001, 12'hFFF}; valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      valid = 1'b0;
      checks++; if (fs_i !== 1'b1) begin failures++; $display("FAIL bypass_frame_start: got %b expected 1", fs_i); end
      checks++; if (rdy_i !== 1'b1) begin failures++; $display("FAIL bypass_ready: got %b expected 1", rdy_i); end
      checks++; if (cnt_i !== 8'd3) begin failures++; $display("FAIL bypass_cnt: got %0d expected 3", cnt_i); end
      capture(ci, wi, cl, wl, cr, wr, n0, bad);
      checks++; if (ci !== I2S_B) begin failures++; $display("FAIL bypass_i2s_data: got %h expected %h", ci, I2S_B); end
      checks++; if (cl !== LJ_B) begin failures++; $display("FAIL bypass_lj_data: got %h expected %h", cl, LJ_B); end
      checks++; if (cr !== RJ_B) begin failures++; $display("FAIL bypass_rj_data: got %h expected %h", cr, RJ_B); end
      checks++; if (cnt_i !== 8'd4) begin failures++; $display("FAIL cnt_after_bypass: got %0d expected 4", cnt_i); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] ci, wi, cl, wl, cr, wr;
      logic n0;
      int bad;
      int n;
      // Two clocks into bit 10 of a frame repeating the bypass sample: BCK high, data bit 1.
      for (int k = 0; k < 42; k++) @(negedge clk);
      checks++; if (bck_i !== 1'b1) begin failures++; $display("FAIL pre_reset_bck: got %b expected 1", bck_i); end
      checks++; if (dat_i !== 1'b1) begin failures++; $display("FAIL pre_reset_data: got %b expected 1", dat_i); end
      rst = 1'b1;
      #1;
      checks++; if (bck_i !== 1'b0) begin failures++; $display("FAIL mid_reset_bck: got %b expected 0", bck_i); end
      checks++; if (dat_i !== 1'b0) begin failures++; $display("FAIL mid_reset_data: got %b expected 0", dat_i); end
      checks++; if (ws_i !== 1'b0) begin failures++; $display("FAIL mid_reset_ws: got %b expected 0", ws_i); end
      checks++; if (cnt_i !== 8'd0) begin failures++; $display("FAIL mid_reset_cnt: got %0d expected 0", cnt_i); end
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (fs_i !== 1'b1 && n < 300);
      checks++; if (n !== 128) begin failures++; $display("FAIL restart_frame_len: got %0d expected 128", n); end
      checks++; if (cnt_i !== 8'd0) begin failures++; $display("FAIL restart_cnt: got %0d expected 0", cnt_i); end
      capture(ci, wi, cl, wl, cr, wr, n0, bad);
      checks++; if (cl !== 32'h0) begin failures++; $display("FAIL restart_lj_data: got %h expected 00000000", cl); end
      checks++; if (cnt_i !== 8'd0) begin failures++; $display("FAIL restart_unarmed_cnt: got %0d expected 0", cnt_i); end
      send(32'h8000_8000, 24'h800_800);
      capture(ci, wi, cl, wl, cr, wr, n0, bad);
      checks++; if (cl !== LJ_C) begin failures++; $display("FAIL sign_conv_lj: got %h expected %h", cl, LJ_C); end
      checks++; if (ci !== I2S_C) begin failures++; $display("FAIL sign_conv_i2s: got %h expected %h", ci, I2S_C); end
      checks++; if (bad !== 0) begin failures++; $display("FAIL restart_timing: got %0d errors expected 0", bad); end
   endtask

   initial begin
      test_reset();
      test_idle();
      test_formats();
      test_underrun();
      test_bypass();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
